// File: rtl/ncc_peak_finder_if.sv
// Handshake bundle between the NCC PE grid, ncc_peak_finder and the match logic.
// PEAK_THRESH_EN adds the thresh input and the res_found flag.
interface ncc_peak_finder_if #(
  parameter int NUM_ROWS = 16,
  parameter int ACC_W    = 8,
  parameter int SCAN_W   = 625,
  parameter int SCAN_H   = 465
);
  localparam int SCORE_W = ACC_W + $clog2(NUM_ROWS);
  localparam int X_W     = $clog2(SCAN_W);
  localparam int Y_W     = $clog2(SCAN_H);

  logic                       start;
  logic [NUM_ROWS*ACC_W-1:0]  acc_in;
  logic                       acc_valid;
  logic                       acc_ready;
  logic                       busy;
  logic                       res_valid;
  logic                       res_ready;
  logic signed [SCORE_W-1:0]  res_score;
  logic [X_W-1:0]             res_x;
  logic [Y_W-1:0]             res_y;
`ifdef PEAK_THRESH_EN
  logic signed [SCORE_W-1:0]  thresh;
  logic                       res_found;
`endif

  modport master (
    output start, acc_in, acc_valid, res_ready,
`ifdef PEAK_THRESH_EN
    output thresh,
    input  res_found,
`endif
    input  acc_ready, busy, res_valid, res_score, res_x, res_y
  );

  modport slave (
    input  start, acc_in, acc_valid, res_ready,
`ifdef PEAK_THRESH_EN
    input  thresh,
    output res_found,
`endif
    output acc_ready, busy, res_valid, res_score, res_x, res_y
  );
endinterface

// File: rtl/ncc_peak_finder.sv
// Reduces each PE-grid beat to a correlation score and reports the raster position of the scan maximum.
// Optional feature macro PEAK_THRESH_EN: registers res_found = (best > thresh) when the result is produced.
module ncc_peak_finder #(
  parameter int NUM_ROWS = 16,
  parameter int ACC_W    = 8,
  parameter int SCAN_W   = 625,
  parameter int SCAN_H   = 465
) (
  input  logic                 clk,
  input  logic                 rst,
  ncc_peak_finder_if.slave     bus
);
  localparam int SCORE_W    = ACC_W + $clog2(NUM_ROWS);
  localparam int X_W        = $clog2(SCAN_W);
  localparam int Y_W        = $clog2(SCAN_H);
  localparam int GROUPS     = 4;
  localparam int ROWS_PER_G = NUM_ROWS / GROUPS;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCAN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCAN_H - 1);
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_n;
  logic   acc_ready_c, busy_c, res_valid_c;
  logic   accept, pipe_empty, enter_done, scan_start;

  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           last_seen;

  logic signed [SCORE_W-1:0] psum_p1 [GROUPS];
  logic [X_W-1:0]            x_p1, x_p2, best_x_p3;
  logic [Y_W-1:0]            y_p1, y_p2, best_y_p3;
  logic signed [SCORE_W-1:0] score_p2, best_p3;
  logic                      vld_p1, vld_p2, vld_p3;

  logic signed [SCORE_W-1:0] res_score_r;
  logic [X_W-1:0]            res_x_r;
  logic [Y_W-1:0]            res_y_r;

  // Sign-extends ROWS_PER_G lanes of group g to SCORE_W and adds them.
  function automatic logic signed [SCORE_W-1:0] group_sum(
    input logic [NUM_ROWS*ACC_W-1:0] lanes,
    input int                        g
  );
    logic signed [SCORE_W-1:0] s;
    logic [ACC_W-1:0]          a;
    s = '0;
    for (int r = 0; r < ROWS_PER_G; r++) begin
      a = lanes[(g*ROWS_PER_G + r)*ACC_W +: ACC_W];
      s = s + {{(SCORE_W-ACC_W){a[ACC_W-1]}}, a};
    end
    return s;
  endfunction

  assign accept     = bus.acc_valid && acc_ready_c;
  assign pipe_empty = !(vld_p1 || vld_p2 || vld_p3);
  assign scan_start = (state == IDLE) && bus.start;
  assign enter_done = (state == SCAN) && (state_n == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    acc_ready_c = 1'b0;
    busy_c      = 1'b1;
    res_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_n = SCAN;
      end
      SCAN: begin
        acc_ready_c = !last_seen;
        if (last_seen && pipe_empty) state_n = DONE;
      end
      DONE: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.acc_ready = acc_ready_c;
  assign bus.busy      = busy_c;
  assign bus.res_valid = res_valid_c;
  assign bus.res_score = res_score_r;
  assign bus.res_x     = res_x_r;
  assign bus.res_y     = res_y_r;

  // Raster position counters and pipeline valids
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      last_seen <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (scan_start) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        last_seen <= 1'b0;
      end else if (accept) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + Y_W'(1);
        end else begin
          x_cnt <= x_cnt + X_W'(1);
        end
        if (x_cnt == X_LAST && y_cnt == Y_LAST) last_seen <= 1'b1;
      end
    end
  end

  // P1: four partial sums, captured only on an accepted beat
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int g = 0; g < GROUPS; g++) psum_p1[g] <= group_sum(bus.acc_in, g);
      x_p1 <= x_cnt;
      y_p1 <= y_cnt;
    end
  end

  // P2: full score
  always_ff @(posedge clk) begin
    score_p2 <= psum_p1[0] + psum_p1[1] + psum_p1[2] + psum_p1[3];
    x_p2     <= x_p1;
    y_p2     <= y_p1;
  end

  // P3: running maximum; strict compare keeps the earliest position on ties
  always_ff @(posedge clk) begin
    if (scan_start) begin
      best_p3   <= SCORE_MIN;
      best_x_p3 <= '0;
      best_y_p3 <= '0;
    end else if (vld_p2 && (score_p2 > best_p3)) begin
      best_p3   <= score_p2;
      best_x_p3 <= x_p2;
      best_y_p3 <= y_p2;
    end
  end

  // Result registers, loaded on entry to DONE and held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      res_score_r <= '0;
      res_x_r     <= '0;
      res_y_r     <= '0;
    end else if (enter_done) begin
      res_score_r <= best_p3;
      res_x_r     <= best_x_p3;
      res_y_r     <= best_y_p3;
    end
  end

`ifdef PEAK_THRESH_EN
  logic res_found_r;
  always_ff @(posedge clk) begin
    if (rst)             res_found_r <= 1'b0;
    else if (enter_done) res_found_r <= (best_p3 > bus.thresh);
  end
  assign bus.res_found = res_found_r;
`endif
endmodule

// File: tb/tb_ncc_peak_finder.sv
// Randomized bench for ncc_peak_finder on a 4x2 scan, checked every cycle against a scan-level model.
module tb_ncc_peak_finder;
  localparam int NR   = 16;
  localparam int AW   = 8;
  localparam int SW   = 4;
  localparam int SH   = 2;
  localparam int NPOS = SW * SH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ncc_peak_finder_if #(.NUM_ROWS(NR), .ACC_W(AW), .SCAN_W(SW), .SCAN_H(SH)) bus ();
  ncc_peak_finder #(.NUM_ROWS(NR), .ACC_W(AW), .SCAN_W(SW), .SCAN_H(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan-level model: phase 0 idle, 1 scanning, 2 result held
  int edge_n = 0;
  int m_phase = 0;
  int m_nacc = 0;
  int m_done_at = -1;
  int m_scores [NPOS];
  int m_score = 0, m_x = 0, m_y = 0, m_found = 0;
  int thresh_v = 16;

  function automatic int beat_score(input logic [NR*AW-1:0] v);
    int s = 0;
    for (int r = 0; r < NR; r++) s += int'($signed(v[r*AW +: AW]));
    return s;
  endfunction

  function automatic logic [NR*AW-1:0] splat(input int v);
    logic [NR*AW-1:0] f;
    for (int r = 0; r < NR; r++) f[r*AW +: AW] = AW'(v);
    return f;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_phase = 0; m_nacc = 0; m_done_at = -1;
      m_score = 0; m_x = 0; m_y = 0; m_found = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin m_phase = 1; m_nacc = 0; m_done_at = -1; end
        1: begin
          if (bus.acc_valid && m_nacc < NPOS) begin
            m_scores[m_nacc] = beat_score(bus.acc_in);
            m_nacc++;
            if (m_nacc == NPOS) m_done_at = edge_n + 4;
          end
          if (edge_n == m_done_at) begin
            int best, bi;
            best = -2048; bi = 0;
            for (int i = 0; i < NPOS; i++)
              if (m_scores[i] > best) begin best = m_scores[i]; bi = i; end
            m_score = best; m_x = bi % SW; m_y = bi / SW;
            m_found = (best > thresh_v) ? 1 : 0;
            m_phase = 2;
          end
        end
        default: if (bus.res_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      int'(bus.busy),      (m_phase != 0) ? 1 : 0);
      check("acc_ready", int'(bus.acc_ready), (m_phase == 1 && m_nacc < NPOS) ? 1 : 0);
      check("res_valid", int'(bus.res_valid), (m_phase == 2) ? 1 : 0);
      check("res_score", int'(bus.res_score), m_score);
      check("res_x",     int'(bus.res_x),     m_x);
      check("res_y",     int'(bus.res_y),     m_y);
`ifdef PEAK_THRESH_EN
      check("res_found", int'(bus.res_found), m_found);
`endif
    end
  end

  logic [NR*AW-1:0] beats [NPOS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_beat(input logic [NR*AW-1:0] v, input int gap_pct);
    int guard;
    while ($urandom_range(99) < gap_pct) begin
      bus.acc_valid = 1'b0;
      bus.acc_in    = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    bus.acc_valid = 1'b1;
    bus.acc_in    = v;
    guard = 0;
    while (!bus.acc_ready && guard < 20) begin tick(); guard++; end
    if (guard >= 20) check("acc_ready_timeout", 0, 1);
    tick();
  endtask

  task automatic run_scan(input int gap_pct, output int lat);
    int t, n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < NPOS; k++) feed_beat(beats[k], gap_pct);
    t = edge_n;
    bus.acc_in = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!bus.res_valid && n < 40) begin tick(); n++; end
    if (n >= 40) check("res_valid_timeout", 0, 1);
    lat = edge_n - t;
    bus.acc_valid = 1'b0;
  endtask

  task automatic release_res(input logic with_start);
    bus.res_ready = 1'b1;
    bus.start     = with_start;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, held;
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.acc_valid = 1'b1;
    bus.acc_in    = {$urandom, $urandom, $urandom, $urandom};
    bus.res_ready = 1'b0;
`ifdef PEAK_THRESH_EN
    bus.thresh = 12'sd16;
`endif
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    check("rst_acc_ready", int'(bus.acc_ready), 0);
    check("rst_busy",      int'(bus.busy),      0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_score", int'(bus.res_score), 0);
    check("rst_res_x",     int'(bus.res_x),     0);
    check("rst_res_y",     int'(bus.res_y),     0);
    rst = 1'b0; bus.start = 1'b0; bus.acc_valid = 1'b0;
    tick();

    // Single peak at position 5
    for (int k = 0; k < NPOS; k++) beats[k] = splat(0);
    beats[5] = splat(1);
    run_scan(0, lat);
    check("peak_latency", lat, 4);
    check("peak_score", int'(bus.res_score), 16);
    check("peak_x", int'(bus.res_x), 1);
    check("peak_y", int'(bus.res_y), 1);
`ifdef PEAK_THRESH_EN
    check("found_thresh16", int'(bus.res_found), 0);
`endif
    release_res(1'b0);

`ifdef PEAK_THRESH_EN
    bus.thresh = 12'sd15; thresh_v = 15;
    run_scan(0, lat);
    check("found_thresh15", int'(bus.res_found), 1);
    release_res(1'b0);
`endif

    // Extremes
    for (int k = 0; k < NPOS; k++) beats[k] = splat(-128);
    run_scan(20, lat);
    check("min_score", int'(bus.res_score), -2048);
    check("min_x", int'(bus.res_x), 0);
    check("min_y", int'(bus.res_y), 0);
    release_res(1'b0);
    for (int k = 0; k < NPOS; k++) beats[k] = splat(127);
    run_scan(0, lat);
    check("max_score", int'(bus.res_score), 2032);
    release_res(1'b0);

    // Tie at positions 2 and 6, with and without gaps
    for (int gp = 0; gp <= 40; gp += 40) begin
      for (int k = 0; k < NPOS; k++) beats[k] = splat(1);
      beats[2] = splat(0); beats[6] = splat(0);
      for (int r = 0; r < 4; r++) begin
        beats[2][r*AW +: AW] = 8'd5;
        beats[6][(r+7)*AW +: AW] = 8'd5;
      end
      run_scan(gp, lat);
      check("tie_score", int'(bus.res_score), 20);
      check("tie_x", int'(bus.res_x), 2);
      check("tie_y", int'(bus.res_y), 0);
      release_res(1'b0);
    end

    // Held result under backpressure; start ignored, including on the release cycle
    for (int k = 0; k < NPOS; k++) beats[k] = splat(int'($urandom_range(20)) - 10);
    run_scan(30, lat);
    held = int'(bus.res_score);
    check("hold_score_model", held, m_score);
    for (int c = 0; c < 10; c++) begin
      bus.start = c[0];
      tick();
    end
    bus.start = 1'b0;
    check("hold_score", int'(bus.res_score), held);
    check("hold_valid", int'(bus.res_valid), 1);
    release_res(1'b1);
    check("release_busy", int'(bus.busy), 0);
    check("release_valid", int'(bus.res_valid), 0);

    // Reset in the middle of a scan
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < 3; k++) feed_beat(splat(3), 0);
    bus.acc_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_busy", int'(bus.busy), 0);
    repeat (10) tick();
    check("midrst_no_result", int'(bus.res_valid), 0);

    // Random scans: full-range lanes, then narrow lanes to provoke ties
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < NPOS; k++)
        for (int r = 0; r < NR; r++)
          beats[k][r*AW +: AW] = (s < 5) ? AW'($urandom) : AW'(int'($urandom_range(2)) - 1);
      run_scan(int'($urandom_range(50)), lat);
      check("rand_latency", lat, 4);
      repeat ($urandom_range(3)) tick();
      release_res(1'($urandom_range(1)));
      repeat ($urandom_range(2)) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
